// File: rtl/hazard_unit_sb_pkg.sv
// Shared types and defaults for the hazard unit.
// The scoreboard, the hazard-unit interface and the top all import this package.
package hazard_pkg;

    localparam int DEF_NUM_REGS       = 32;
    localparam int DEF_REG_AW         = 5;
    localparam int DEF_NUM_FWD_STAGES = 2;
    localparam int DEF_MAX_LL         = 4;

    // A select of 0 means "regfile", so the width must also encode NUM_FWD_STAGES.
    function automatic int fwd_width(input int n_stages);
        return (n_stages < 1) ? 1 : $clog2(n_stages + 1);
    endfunction

    localparam int DEF_FWD_W = fwd_width(DEF_NUM_FWD_STAGES);

    typedef logic [DEF_REG_AW-1:0] reg_idx_t;
    typedef logic [DEF_FWD_W-1:0]  fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = '0;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline <-> hazard unit bundle: ID/EX operand info in, stall/flush/forward selects out.
// The master modport is the pipeline side and the slave modport is the hazard unit.
interface hazard_unit_sb_if
    import hazard_pkg::*;
#(
    parameter int REG_AW         = DEF_REG_AW,
    parameter int NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
    parameter int MAX_LL         = DEF_MAX_LL
);
    localparam int FWD_W = fwd_width(NUM_FWD_STAGES);
    localparam int CNT_W = $clog2(MAX_LL + 1);

    logic [REG_AW-1:0]                rs1_d;
    logic [REG_AW-1:0]                rs2_d;
    logic                             rs1_used_d;
    logic                             rs2_used_d;
    logic [REG_AW-1:0]                rd_d;
    logic                             reg_write_d;
    logic                             ll_d;
    logic [REG_AW-1:0]                rd_e;
    logic [REG_AW-1:0]                rs1_e;
    logic [REG_AW-1:0]                rs2_e;
    logic                             rs1_used_e;
    logic                             rs2_used_e;
    logic                             load_e;
    logic                             ll_issue_e;
    logic [NUM_FWD_STAGES*REG_AW-1:0] stage_rd;
    logic [NUM_FWD_STAGES-1:0]        stage_wr;
    logic                             ll_done;
    logic [REG_AW-1:0]                ll_done_rd;
    logic                             branch_taken;
    logic                             div_busy_e;
    logic                             mem_ready_m;

    logic                             stall;
    logic                             flush;
    logic [FWD_W-1:0]                 fwd_rs1;
    logic [FWD_W-1:0]                 fwd_rs2;
    logic                             div_stall;
    logic                             cache_stall;
    logic [CNT_W-1:0]                 ll_count;

    modport master (
        output rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d, ll_d,
        output rd_e, rs1_e, rs2_e, rs1_used_e, rs2_used_e, load_e, ll_issue_e,
        output stage_rd, stage_wr, ll_done, ll_done_rd, branch_taken,
        output div_busy_e, mem_ready_m,
        input  stall, flush, fwd_rs1, fwd_rs2, div_stall, cache_stall, ll_count
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d, ll_d,
        input  rd_e, rs1_e, rs2_e, rs1_used_e, rs2_used_e, load_e, ll_issue_e,
        input  stage_rd, stage_wr, ll_done, ll_done_rd, branch_taken,
        input  div_busy_e, mem_ready_m,
        output stall, flush, fwd_rs1, fwd_rs2, div_stall, cache_stall, ll_count
    );

endinterface

// File: rtl/hazard_unit_sb_reg_scoreboard.sv
// Per-register pending bits for long-latency writers plus an outstanding-op counter.
// pend_eff hides a register whose result is being written back this very cycle.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int MAX_LL   = DEF_MAX_LL,
    localparam int CNT_W   = $clog2(MAX_LL + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic                done,
    input  logic [REG_AW-1:0]   done_rd,
    output logic [NUM_REGS-1:0] pend_eff,
    output logic [CNT_W-1:0]    ll_count
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                issue_hit;
    logic                done_hit;

    assign issue_hit = issue_en && (issue_rd != '0);
    assign done_hit  = done && pending_q[done_rd];

    // Issue is applied after done so a same-register issue/done pair leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (done_hit) begin
            pending_d[done_rd] = 1'b0;
        end
        if (issue_hit) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        count_d = count_q;
        case ({issue_hit, done_hit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_eff
            if (gi == 0) begin : g_x0
                assign pend_eff[gi] = 1'b0;
            end else begin : g_xn
                assign pend_eff[gi] = pending_q[gi] && !(done && (done_rd == REG_AW'(gi)));
            end
        end
    endgenerate

    assign ll_count = count_q;

    a_done_pending: assert property (@(posedge clk) disable iff (rst) done |-> pending_q[done_rd])
        else $error("ll_done to a register with no pending LL op");

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard unit: LL scoreboard stalls, load-use stalls, multi-stage forwarding and
// multi-cycle flush after a taken branch. All outputs are forced low while rst is high.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int REG_AW         = DEF_REG_AW,
    parameter int NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
    parameter int MAX_LL         = DEF_MAX_LL,
    parameter int FLUSH_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             rst,
    hazard_unit_sb_if.slave  hz
);

    localparam int FWD_W = fwd_width(NUM_FWD_STAGES);
    localparam int CNT_W = $clog2(MAX_LL + 1);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    logic [NUM_REGS-1:0] pend_eff;
    logic [CNT_W-1:0]    ll_count;
    logic [REG_AW-1:0]   stage_rd_a [NUM_FWD_STAGES];
    logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic load_use, sb_hit, ll_full;
    logic stall_int, flush_int, advance;
    logic [FWD_W-1:0] fwd1, fwd2;

    generate
        for (genvar gi = 0; gi < NUM_FWD_STAGES; gi++) begin : g_stage
            assign stage_rd_a[gi] = hz.stage_rd[gi*REG_AW +: REG_AW];
        end
    endgenerate

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .MAX_LL   (MAX_LL)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .issue_en (hz.ll_issue_e && advance),
        .issue_rd (hz.rd_e),
        .done     (hz.ll_done),
        .done_rd  (hz.ll_done_rd),
        .pend_eff (pend_eff),
        .ll_count (ll_count)
    );

    always_comb begin
        load_use = hz.load_e && (hz.rd_e != '0)
                   && ((hz.rs1_used_d && (hz.rd_e == hz.rs1_d))
                    || (hz.rs2_used_d && (hz.rd_e == hz.rs2_d)));
        // The rd_d term catches WAW against an outstanding LL write.
        sb_hit   = (hz.rs1_used_d  && pend_eff[hz.rs1_d])
                || (hz.rs2_used_d  && pend_eff[hz.rs2_d])
                || (hz.reg_write_d && pend_eff[hz.rd_d]);
        ll_full  = hz.ll_d && (ll_count == CNT_W'(MAX_LL)) && !hz.ll_done;
        flush_int = hz.branch_taken || (flush_cnt_q != '0);
        stall_int = (load_use || sb_hit || ll_full) && !flush_int;
        advance   = hz.mem_ready_m && !hz.div_busy_e && !stall_int;
    end

    // Iterate oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd1 = FWD_W'(FWD_REGFILE);
        fwd2 = FWD_W'(FWD_REGFILE);
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (hz.stage_wr[k] && (stage_rd_a[k] != '0)) begin
                if (hz.rs1_used_e && (stage_rd_a[k] == hz.rs1_e)) begin
                    fwd1 = FWD_W'(k + 1);
                end
                if (hz.rs2_used_e && (stage_rd_a[k] == hz.rs2_e)) begin
                    fwd2 = FWD_W'(k + 1);
                end
            end
        end
    end

    // A new branch reloads the counter; cache stalls deliberately do not hold it.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (hz.branch_taken) begin
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall       = !rst && stall_int;
    assign hz.flush       = !rst && flush_int;
    assign hz.fwd_rs1     = rst ? '0 : fwd1;
    assign hz.fwd_rs2     = rst ? '0 : fwd2;
    assign hz.div_stall   = !rst && hz.div_busy_e;
    assign hz.cache_stall = !rst && !hz.mem_ready_m;
    assign hz.ll_count    = rst ? '0 : ll_count;

    a_issue_vs_branch: assert property (@(posedge clk) disable iff (rst)
        !(hz.ll_issue_e && hz.branch_taken))
        else $error("ll_issue_e and branch_taken asserted together");

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_unit_sb;
    import hazard_pkg::*;

    localparam int REG_AW = 5;
    localparam int NFS    = 3;
    localparam int MAXLL  = 3;
    localparam int FLUSHC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_sb_if #(.REG_AW(REG_AW), .NUM_FWD_STAGES(NFS), .MAX_LL(MAXLL)) hz ();

    hazard_unit_sb #(
        .NUM_REGS       (32),
        .REG_AW         (REG_AW),
        .NUM_FWD_STAGES (NFS),
        .MAX_LL         (MAXLL),
        .FLUSH_CYCLES   (FLUSHC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    logic [9:0] exp_q [$];
    string      name_q [$];
    int checks = 0;
    int errors = 0;
    int pushes = 0;

    // {stall, flush, fwd_rs1, fwd_rs2, div_stall, cache_stall, ll_count}
    function automatic logic [9:0] mk(input bit s, input bit f, input int f1, input int f2,
                                      input bit dv, input bit ch, input int lc);
        return {s, f, 2'(f1), 2'(f2), dv, ch, 2'(lc)};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e, g;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {hz.stall, hz.flush, hz.fwd_rs1, hz.fwd_rs2, hz.div_stall, hz.cache_stall, hz.ll_count};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s got=%b exp=%b (stall flush fwd1 fwd2 div cache cnt)", nm, g, e);
            end else begin
                $display("ok   %s out=%b", nm, g);
            end
        end
    end

    task automatic clr();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_used_d = 0; hz.rs2_used_d = 0;
        hz.rd_d = '0; hz.reg_write_d = 0; hz.ll_d = 0;
        hz.rd_e = '0; hz.rs1_e = '0; hz.rs2_e = '0; hz.rs1_used_e = 0; hz.rs2_used_e = 0;
        hz.load_e = 0; hz.ll_issue_e = 0;
        hz.stage_rd = '0; hz.stage_wr = '0;
        hz.ll_done = 0; hz.ll_done_rd = '0; hz.branch_taken = 0;
        hz.div_busy_e = 0; hz.mem_ready_m = 1;
    endtask

    // Inputs are already applied (posedge+1); queue the expectation and move one cycle.
    task automatic cyc(input string nm, input logic [9:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        pushes++;
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        hz.mem_ready_m = 0;
        hz.div_busy_e  = 1;
        @(posedge clk);
        #1;
        cyc("reset_hold", mk(0,0,0,0,0,0,0));
        rst = 1'b0;

        // Divider issue to x5, dependent reader stalls until ll_done bypass.
        hz.rd_e = 5; hz.ll_issue_e = 1;
        cyc("div_issue", mk(0,0,0,0,0,0,0));
        for (int t = 1; t <= 9; t++) begin
            hz.rs1_d = 5; hz.rs1_used_d = 1;
            if (t == 5) begin
                hz.rd_e = 9; hz.ll_issue_e = 1;   // ignored: not advancing
            end
            cyc($sformatf("sb_stall_t%0d", t), mk(1,0,0,0,0,0,1));
        end
        hz.rs1_d = 5; hz.rs1_used_d = 1; hz.ll_done = 1; hz.ll_done_rd = 5;
        cyc("ll_done_bypass", mk(0,0,0,0,0,0,1));
        hz.rs1_d = 5; hz.rs1_used_d = 1;
        cyc("ll_drained", mk(0,0,0,0,0,0,0));
        hz.div_busy_e = 1;
        cyc("div_stall", mk(0,0,0,0,1,0,0));
        hz.mem_ready_m = 0;
        cyc("cache_stall", mk(0,0,0,0,0,1,0));

        // Load-use.
        hz.load_e = 1; hz.rd_e = 7; hz.rs2_d = 7; hz.rs2_used_d = 1;
        cyc("load_use", mk(1,0,0,0,0,0,0));
        hz.rs2_d = 7; hz.rs2_used_d = 1;
        cyc("load_use_gone", mk(0,0,0,0,0,0,0));
        hz.load_e = 1; hz.rd_e = 7; hz.rs2_d = 7; hz.rs2_used_d = 0;
        cyc("load_unused", mk(0,0,0,0,0,0,0));
        hz.load_e = 1; hz.rd_e = 0; hz.rs2_d = 0; hz.rs2_used_d = 1;
        cyc("load_x0", mk(0,0,0,0,0,0,0));

        // Forwarding priority.
        hz.stage_rd = {5'd3, 5'd3, 5'd3}; hz.stage_wr = 3'b111; hz.rs1_e = 3; hz.rs1_used_e = 1;
        hz.rs2_e = 3; hz.rs2_used_e = 1;
        cyc("fwd_youngest", mk(0,0,1,1,0,0,0));
        hz.stage_rd = {5'd3, 5'd3, 5'd3}; hz.stage_wr = 3'b110; hz.rs1_e = 3; hz.rs1_used_e = 1;
        cyc("fwd_stage1", mk(0,0,2,0,0,0,0));
        hz.stage_rd = {5'd3, 5'd3, 5'd3}; hz.stage_wr = 3'b100; hz.rs1_e = 3; hz.rs1_used_e = 1;
        hz.rs2_e = 3; hz.rs2_used_e = 1;
        cyc("fwd_stage2", mk(0,0,3,3,0,0,0));
        hz.stage_rd = {5'd3, 5'd3, 5'd3}; hz.stage_wr = 3'b111; hz.rs1_e = 3; hz.rs1_used_e = 0;
        cyc("fwd_unused", mk(0,0,0,0,0,0,0));
        hz.stage_rd = {5'd6, 5'd3, 5'd0}; hz.stage_wr = 3'b111; hz.rs1_e = 0; hz.rs1_used_e = 1;
        hz.rs2_e = 6; hz.rs2_used_e = 1;
        cyc("fwd_x0_skip", mk(0,0,0,3,0,0,0));

        // LL capacity.
        for (int i = 1; i <= 3; i++) begin
            hz.rd_e = 5'(i); hz.ll_issue_e = 1;
            cyc($sformatf("ll_issue_%0d", i), mk(0,0,0,0,0,0,i-1));
        end
        hz.ll_d = 1; hz.rd_d = 10; hz.reg_write_d = 1;
        cyc("ll_full", mk(1,0,0,0,0,0,3));
        hz.ll_d = 1; hz.rd_d = 10; hz.reg_write_d = 1; hz.ll_done = 1; hz.ll_done_rd = 1;
        cyc("ll_full_done", mk(0,0,0,0,0,0,3));
        hz.ll_done = 1; hz.ll_done_rd = 2;
        cyc("ll_drain_2", mk(0,0,0,0,0,0,2));
        hz.ll_done = 1; hz.ll_done_rd = 3;
        cyc("ll_drain_3", mk(0,0,0,0,0,0,1));
        cyc("ll_empty", mk(0,0,0,0,0,0,0));

        // Flush: single branch, counter runs through a cache stall.
        hz.branch_taken = 1;
        cyc("flush_b0", mk(0,1,0,0,0,0,0));
        hz.mem_ready_m = 0;
        cyc("flush_b1_cache", mk(0,1,0,0,0,1,0));
        cyc("flush_b2", mk(0,1,0,0,0,0,0));
        cyc("flush_end", mk(0,0,0,0,0,0,0));

        // Back-to-back branches with load-use hits suppressed during flush.
        hz.branch_taken = 1;
        cyc("flush2_t0", mk(0,1,0,0,0,0,0));
        hz.branch_taken = 1;
        cyc("flush2_t1", mk(0,1,0,0,0,0,0));
        hz.load_e = 1; hz.rd_e = 7; hz.rs1_d = 7; hz.rs1_used_d = 1;
        cyc("flush2_t2_lu", mk(0,1,0,0,0,0,0));
        hz.load_e = 1; hz.rd_e = 7; hz.rs1_d = 7; hz.rs1_used_d = 1;
        cyc("flush2_t3_lu", mk(0,1,0,0,0,0,0));
        hz.load_e = 1; hz.rd_e = 7; hz.rs1_d = 7; hz.rs1_used_d = 1;
        cyc("flush2_end_lu", mk(1,0,0,0,0,0,0));

        // Reset in the middle of three outstanding LL ops.
        for (int i = 4; i <= 6; i++) begin
            hz.rd_e = 5'(i); hz.ll_issue_e = 1;
            cyc($sformatf("rst_issue_%0d", i), mk(0,0,0,0,0,0,i-4));
        end
        hz.rd_d = 5; hz.reg_write_d = 1;
        cyc("waw_stall", mk(1,0,0,0,0,0,3));
        rst = 1'b1;
        hz.rs1_d = 4; hz.rs1_used_d = 1; hz.mem_ready_m = 0; hz.div_busy_e = 1;
        hz.branch_taken = 1;
        hz.stage_rd = {5'd3, 5'd3, 5'd3}; hz.stage_wr = 3'b111; hz.rs1_e = 3; hz.rs1_used_e = 1;
        cyc("rst_mid", mk(0,0,0,0,0,0,0));
        rst = 1'b0;
        hz.rs1_d = 4; hz.rs1_used_d = 1; hz.rd_d = 6; hz.reg_write_d = 1;
        cyc("rst_after", mk(0,0,0,0,0,0,0));

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0 || checks != pushes) begin
            errors++;
            $display("FAIL drain got=%0d checked exp=%0d pushed", checks, pushes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
